// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: single-outstanding memory responder for the core's
// load/store port. It holds a word-organised local RAM, inserts LATENCY wait
// cycles, applies RISC-V byte/halfword lane selection and extension, and
// reports misaligned, out-of-range and illegal-size accesses.
//
// state | meaning
// IDLE  | ready for a request (req_ready registered high one edge after entry)
// WAIT  | request captured, counting down wait cycles
// RESP  | response held on the outputs until resp_ready
module riscv_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_size,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic        w_accept;
  logic        w_commit;
  logic        w_write;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_size;
  logic [31:0] w_off;
  logic        w_oor;
  logic        w_bad_size;
  logic        w_misal;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic [31:0] w_word;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;
  logic [31:0] w_merged;

  assign w_accept = (r_state == IDLE) && r_req_ready && i_req_valid;
  // With zero latency the commit edge is the acceptance edge itself, so the
  // access is evaluated straight from the request inputs in that case.
  assign w_commit = (w_accept && (LAT == 4'd0)) ||
                    ((r_state == WAIT) && (r_cnt == 4'd1));

  assign w_write  = w_accept ? i_req_write : r_write;
  assign w_addr   = w_accept ? i_req_addr  : r_addr;
  assign w_wdata  = w_accept ? i_req_wdata : r_wdata;
  assign w_size   = w_accept ? i_req_size  : r_size;

  assign w_off      = w_addr - BASE_ADDR;
  assign w_oor      = (w_addr < BASE_ADDR) || ({1'b0, w_off} >= SPAN);
  assign w_bad_size = (w_size == 3'b011) || (w_size == 3'b110) ||
                      (w_size == 3'b111) || (w_write && w_size[2]);
  assign w_misal    = ((w_size[1:0] == 2'b01) && w_addr[0]) ||
                      ((w_size[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
  assign w_err      = w_oor || w_bad_size || w_misal;

  assign w_idx     = w_off[AW+1:2];
  assign w_word    = r_mem[w_idx];
  assign w_shifted = w_word >> {w_addr[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_sext    = ~w_size[2];

  // Load lane selection with sign or zero extension.
  always_comb begin
    w_load = w_word;
    case (w_size[1:0])
      2'b00:   w_load = {{24{w_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{w_sext & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Store byte-enable merge; unselected lanes keep the current word.
  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = w_wdata;
    w_merged = w_word;
    case (w_size[1:0])
      2'b00: begin
        w_be     = 4'b0001 << w_addr[1:0];
        w_wlanes = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = w_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      w_merged[8*i +: 8] = w_be[i] ? w_wlanes[8*i +: 8] : w_word[8*i +: 8];
    end
  end

  // RAM write at the commit edge; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (i_reset && w_commit && w_write && !w_err) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Request/response sequencer with registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_size       <= 3'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_write     <= i_req_write;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_size      <= i_req_size;
            r_cnt       <= LAT;
            r_req_ready <= 1'b0;
            if (LAT == 4'd0) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_err;
              r_rdata      <= (w_write || w_err) ? 32'd0 : w_load;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_req_ready <= 1'b0;
          if (w_commit) begin
            r_state      <= RESP;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_rdata      <= (w_write || w_err) ? 32'd0 : w_load;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Testbench for riscv_mem_responder: three builds (LATENCY 0, 2, 15) share
// request fields and resp_ready; each has its own req_valid and outputs.
module tb_riscv_mem_responder;

  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010,
                         SBU = 3'b100, SHU = 3'b101;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  size;
  logic        resp_ready;
  logic [2:0]  v, rdy, rv, er;
  logic [31:0] rd [3];

  int n_checks = 0;
  int n_fail   = 0;

  riscv_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(v[0]), .o_req_ready(rdy[0]),
    .i_req_write(wr), .i_req_addr(addr), .i_req_wdata(wdata), .i_req_size(size),
    .o_resp_valid(rv[0]), .i_resp_ready(resp_ready), .o_resp_rdata(rd[0]),
    .o_resp_err(er[0]));

  riscv_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(v[1]), .o_req_ready(rdy[1]),
    .i_req_write(wr), .i_req_addr(addr), .i_req_wdata(wdata), .i_req_size(size),
    .o_resp_valid(rv[1]), .i_resp_ready(resp_ready), .o_resp_rdata(rd[1]),
    .o_resp_err(er[1]));

  riscv_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(15)) u_dut15 (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(v[2]), .o_req_ready(rdy[2]),
    .i_req_write(wr), .i_req_addr(addr), .i_req_wdata(wdata), .i_req_size(size),
    .o_resp_valid(rv[2]), .i_resp_ready(resp_ready), .o_resp_rdata(rd[2]),
    .o_resp_err(er[2]));

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction on DUT d; lat counts cycles from the acceptance
  // cycle to the first cycle with resp_valid high (1 = the very next cycle).
  task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] sz,
                        output logic [31:0] od, output logic oe, output int lat);
    int n;
    n = 0;
    while (!rdy[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    wr = w; addr = a; wdata = wd; size = sz;
    v[d] = 1'b1;
    @(posedge clk); #1;
    v[d] = 1'b0;
    lat = 1;
    while (!rv[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    od = rd[d];
    oe = er[d];
    @(posedge clk); #1;
  endtask

  // Hold req_valid high and measure spacing between successive acceptances.
  task automatic tput(input int d, input int period, input string name);
    int last, seen, k;
    last = -1; seen = 0;
    wr = 1'b0; addr = 32'h10; size = SW;
    v[d] = 1'b1;
    for (int c = 0; c < 80 && seen < 4; c++) begin
      if (rdy[d]) begin
        if (last >= 0) check(name, c - last, period);
        last = c;
        seen++;
      end
      @(posedge clk); #1;
    end
    v[d] = 1'b0;
    check({name, "_count"}, seen, 4);
    k = 0;
    while (!rdy[d] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    logic [31:0] od;
    logic        oe;
    int          lat;
    int          cnt;

    rst_n = 1'b0; v = 3'b000; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    size = SW; resp_ready = 1'b1;

    tbl.push_back('{"sw_10",        1'b1, 32'h10,   32'hDEADBEEF, SW,     32'h0,        1'b0});
    tbl.push_back('{"lw_10",        1'b0, 32'h10,   32'h0,        SW,     32'hDEADBEEF, 1'b0});
    tbl.push_back('{"sw_10_init",   1'b1, 32'h10,   32'h11223344, SW,     32'h0,        1'b0});
    tbl.push_back('{"sb_13",        1'b1, 32'h13,   32'h00000080, SB,     32'h0,        1'b0});
    tbl.push_back('{"lw_10_merged", 1'b0, 32'h10,   32'h0,        SW,     32'h80223344, 1'b0});
    tbl.push_back('{"lb_13",        1'b0, 32'h13,   32'h0,        SB,     32'hFFFFFF80, 1'b0});
    tbl.push_back('{"lbu_13",       1'b0, 32'h13,   32'h0,        SBU,    32'h00000080, 1'b0});
    tbl.push_back('{"lh_12",        1'b0, 32'h12,   32'h0,        SH,     32'hFFFF8022, 1'b0});
    tbl.push_back('{"lhu_12",       1'b0, 32'h12,   32'h0,        SHU,    32'h00008022, 1'b0});
    tbl.push_back('{"lh_10",        1'b0, 32'h10,   32'h0,        SH,     32'h00003344, 1'b0});
    tbl.push_back('{"lb_11",        1'b0, 32'h11,   32'h0,        SB,     32'h00000033, 1'b0});
    tbl.push_back('{"lw_02_misal",  1'b0, 32'h02,   32'h0,        SW,     32'h0,        1'b1});
    tbl.push_back('{"sw_04",        1'b1, 32'h04,   32'h0,        SW,     32'h0,        1'b0});
    tbl.push_back('{"sh_05_misal",  1'b1, 32'h05,   32'h0000BEEF, SH,     32'h0,        1'b1});
    tbl.push_back('{"lw_04_same",   1'b0, 32'h04,   32'h0,        SW,     32'h0,        1'b0});
    tbl.push_back('{"lw_oor",       1'b0, 32'h1000, 32'h0,        SW,     32'h0,        1'b1});
    tbl.push_back('{"sw_ffc",       1'b1, 32'hFFC,  32'hA5A5A5A5, SW,     32'h0,        1'b0});
    tbl.push_back('{"lw_ffc",       1'b0, 32'hFFC,  32'h0,        SW,     32'hA5A5A5A5, 1'b0});
    tbl.push_back('{"size_011",     1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1});
    tbl.push_back('{"store_sz100",  1'b1, 32'h10,   32'hFFFFFFFF, SBU,    32'h0,        1'b1});
    tbl.push_back('{"lw_10_kept",   1'b0, 32'h10,   32'h0,        SW,     32'h80223344, 1'b0});
    tbl.push_back('{"sw_24",        1'b1, 32'h24,   32'h0,        SW,     32'h0,        1'b0});
    tbl.push_back('{"sh_26",        1'b1, 32'h26,   32'h1234CAFE, SH,     32'h0,        1'b0});
    tbl.push_back('{"lw_24",        1'b0, 32'h24,   32'h0,        SW,     32'hCAFE0000, 1'b0});
    tbl.push_back('{"sw_20_zero",   1'b1, 32'h20,   32'h0,        SW,     32'h0,        1'b0});

    // Reset values and release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  rdy[1], 1'b0);
    check("rst_resp_valid", rv[1],  1'b0);
    check("rst_resp_rdata", rd[1],  32'h0);
    check("rst_resp_err",   er[1],  1'b0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", rdy[1], 1'b0);
    @(posedge clk); #1;
    check("ready_after_edge", rdy[1], 1'b1);

    // Directed vectors on the LATENCY=2 build.
    foreach (tbl[i]) begin
      do_txn(1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].size, od, oe, lat);
      check({tbl[i].name, "_rdata"}, od, tbl[i].exp_rd);
      check({tbl[i].name, "_err"},   oe, tbl[i].exp_err);
      check({tbl[i].name, "_lat"},   lat, 3);
    end

    // Backpressure: response held 5 cycles, a store pulse meanwhile ignored.
    resp_ready = 1'b0;
    wr = 1'b0; addr = 32'h10; size = SW;
    v[1] = 1'b1;
    @(posedge clk); #1;
    v[1] = 1'b0;
    cnt = 0;
    while (!rv[1] && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", rv[1], 1'b1);
      check("bp_rdata", rd[1], 32'h80223344);
      check("bp_ready", rdy[1], 1'b0);
      if (k == 1) begin
        wr = 1'b1; addr = 32'h24; wdata = 32'hFFFFFFFF; size = SW;
        v[1] = 1'b1;
      end else begin
        v[1] = 1'b0;
      end
      @(posedge clk); #1;
    end
    v[1] = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_done_valid", rv[1],  1'b0);
    check("bp_done_ready", rdy[1], 1'b1);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rv[1]) cnt++;
    end
    check("bp_no_phantom_resp", cnt, 0);
    do_txn(1, 1'b0, 32'h24, 32'h0, SW, od, oe, lat);
    check("bp_store_ignored", od, 32'hCAFE0000);

    // Reset during WAIT of a store: no response, store discarded.
    wr = 1'b1; addr = 32'h20; wdata = 32'h55555555; size = SW;
    v[1] = 1'b1;
    @(posedge clk); #1;
    v[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", rv[1], 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rv[1]) cnt++;
    end
    check("midrst_no_resp", cnt, 0);
    do_txn(1, 1'b0, 32'h20, 32'h0, SW, od, oe, lat);
    check("midrst_lw_20", od, 32'h0);
    check("midrst_lw_20_err", oe, 1'b0);
    do_txn(1, 1'b0, 32'h10, 32'h0, SW, od, oe, lat);
    check("committed_survives_rst", od, 32'h80223344);

    // LATENCY = 0 and 15 builds: latency and data path.
    do_txn(0, 1'b1, 32'h8, 32'h12345678, SW, od, oe, lat);
    check("l0_sw_lat", lat, 1);
    do_txn(0, 1'b0, 32'h8, 32'h0, SW, od, oe, lat);
    check("l0_lw_lat", lat, 1);
    check("l0_lw_rdata", od, 32'h12345678);
    do_txn(0, 1'b0, 32'h9, 32'h0, SB, od, oe, lat);
    check("l0_lb_rdata", od, 32'h00000056);
    do_txn(0, 1'b0, 32'h9, 32'h0, SH, od, oe, lat);
    check("l0_lh_misal_err", oe, 1'b1);
    do_txn(2, 1'b1, 32'h8, 32'h87654321, SW, od, oe, lat);
    check("l15_sw_lat", lat, 16);
    do_txn(2, 1'b0, 32'hA, 32'h0, SH, od, oe, lat);
    check("l15_lh_lat", lat, 16);
    check("l15_lh_rdata", od, 32'hFFFF8765);

    // Back-to-back throughput with resp_ready high.
    tput(0, 2,  "tput_l0");
    tput(1, 4,  "tput_l2");
    tput(2, 17, "tput_l15");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
